seq_detect_param: RTL and testbench

- Parametrised serial pattern detector; successor to the fixed 3-bit "101" Mealy detector.
- Pattern width and pattern are generic; pattern, don't-care mask and overlap mode are runtime-programmable.
- Input bits are qualified by a valid strobe.
- Emits a registered one-cycle hit pulse; sits between a serial bit source and control/status logic.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_hit_counter.sv | 37 +++
 rtl/seq_detect_param.sv | 132 +++++++++++++
 tb/tb_seq_detect_param.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
// Imported by seq_detect_param and seq_hit_counter.
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FILL  = 2'd1,
        S_ARMED = 2'd2
    } state_t;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 32;

    // Slice [PAT_W-1:0] of this for an all-compare mask of any legal width.
    localparam logic [PAT_W_MAX-1:0] MASK_ALL_ONES = '1;

endpackage

// File: rtl/seq_hit_counter.sv
// Saturating hit counter with synchronous clear; clear beats increment.
// Only instantiated when SEQ_DET_HIT_CNT_EN is defined.
module seq_hit_counter
    import seq_det_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial pattern detector with programmable pattern, don't-care mask and overlap mode.
// Optional saturating hit counter (hit_cnt/cnt_clr) enabled by SEQ_DET_HIT_CNT_EN.
module seq_detect_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 3,
    parameter logic [PAT_W-1:0] PAT_RST = 3'b101,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din_vld,
    input  logic             din,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic [PAT_W-1:0] cfg_mask,
    input  logic             cfg_ovl,
    output logic             hit,
    output logic             armed
`ifdef SEQ_DET_HIT_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] hit_cnt
`endif
);

    localparam int               FILL_W    = $clog2(PAT_W);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    if ((PAT_W < PAT_W_MIN) || (PAT_W > PAT_W_MAX) || (CNT_W < 1)) begin : g_bad_param
        $error("seq_detect_param: PAT_W must be 2..32 and CNT_W >= 1");
    end

    state_t             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [PAT_W-1:0]   mask_q, mask_d;
    logic               ovl_q, ovl_d;
    logic [PAT_W-2:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               hit_q, hit_d;
    logic               armed_q, armed_d;
    logic [PAT_W-1:0]   window;
    logic               match;

    // Newest bit sits at window[0]; the oldest history bit lines up with pat_q[PAT_W-1].
    always_comb begin
        window = {hist_q, din};
        match  = (state_q == S_ARMED) && din_vld && (((window ^ pat_q) & mask_q) == '0);
    end

    always_comb begin
        pat_d  = pat_q;
        mask_d = mask_q;
        ovl_d  = ovl_q;
        hist_d = hist_q;
        fill_d = fill_q;
        hit_d  = 1'b0;
        if (cfg_load) begin
            pat_d  = cfg_pat;
            mask_d = cfg_mask;
            ovl_d  = cfg_ovl;
            hist_d = '0;
            fill_d = '0;
        end else if (din_vld) begin
            hit_d = match;
            if (match && !ovl_q) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = window[PAT_W-2:0];
                if (fill_q != FILL_FULL) begin
                    fill_d = fill_q + 1'b1;
                end
            end
        end
    end

    // State tracks fill; for PAT_W=2 a single accepted bit arms the detector.
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            state_d = S_EMPTY;
        end else if (din_vld) begin
            case (state_q)
                S_EMPTY: state_d = (PAT_W == PAT_W_MIN) ? S_ARMED : S_FILL;
                S_FILL:  state_d = (fill_q == (FILL_FULL - 1'b1)) ? S_ARMED : S_FILL;
                S_ARMED: state_d = (match && !ovl_q) ? S_EMPTY : S_ARMED;
                default: state_d = S_EMPTY;
            endcase
        end
        armed_d = (state_d == S_ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_EMPTY;
            pat_q   <= PAT_RST;
            mask_q  <= MASK_ALL_ONES[PAT_W-1:0];
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            hit_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            mask_q  <= mask_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            hit_q   <= hit_d;
            armed_q <= armed_d;
        end
    end

    assign hit   = hit_q;
    assign armed = armed_q;

`ifdef SEQ_DET_HIT_CNT_EN
    // Counts on hit_d so hit_cnt changes on the same edge that raises hit.
    seq_hit_counter #(
        .CNT_W (CNT_W)
    ) u_hit_counter (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (hit_d),
        .cnt (hit_cnt)
    );
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios plus random traffic, checked by a
// queue-based scoreboard fed from a bit-list reference model.
module tb_seq_detect_param;

    localparam int               PAT_W   = 4;
    localparam int               CNT_W   = 2;
    localparam logic [PAT_W-1:0] PAT_RST = 4'b1010;
    localparam int               EW      = CNT_W + 2;
    localparam int               CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             din_vld;
    logic             din;
    logic             cfg_load;
    logic [PAT_W-1:0] cfg_pat;
    logic [PAT_W-1:0] cfg_mask;
    logic             cfg_ovl;
    logic             hit;
    logic             armed;
    logic             cnt_clr;
    logic [CNT_W-1:0] dut_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int hit_seen = 0;

    logic [EW-1:0] exp_q[$];

    // reference model state
    logic [PAT_W-1:0] m_pat;
    logic [PAT_W-1:0] m_mask;
    logic             m_ovl;
    bit               m_hist[$];
    int               m_cnt;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    seq_detect_param #(
        .PAT_W   (PAT_W),
        .PAT_RST (PAT_RST),
        .CNT_W   (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .din_vld  (din_vld),
        .din      (din),
        .cfg_load (cfg_load),
        .cfg_pat  (cfg_pat),
        .cfg_mask (cfg_mask),
        .cfg_ovl  (cfg_ovl),
        .hit      (hit),
        .armed    (armed)
`ifdef SEQ_DET_HIT_CNT_EN
        ,
        .cnt_clr  (cnt_clr),
        .hit_cnt  (dut_cnt)
`endif
    );

`ifndef SEQ_DET_HIT_CNT_EN
    assign dut_cnt = '0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Keeps the accepted bits since the last flush (oldest first, at most PAT_W-1).
    task automatic model_step(input logic r, input logic vld, input logic d, input logic load,
                              input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                              input logic o, input logic c, output logic [EW-1:0] e);
        logic exp_hit;
        logic is_match;
        bit   b;
        int   pos;
        exp_hit = 1'b0;
        if (r) begin
            m_pat  = PAT_RST;
            m_mask = '1;
            m_ovl  = 1'b1;
            m_hist.delete();
            m_cnt  = 0;
        end else begin
            if (load) begin
                m_pat  = p;
                m_mask = m;
                m_ovl  = o;
                m_hist.delete();
            end else if (vld) begin
                if (m_hist.size() == PAT_W - 1) begin
                    is_match = 1'b1;
                    for (int i = 0; i < PAT_W; i++) begin
                        b   = (i < PAT_W - 1) ? m_hist[i] : bit'(d);
                        pos = PAT_W - 1 - i;
                        if (m_mask[pos] && (b != m_pat[pos])) is_match = 1'b0;
                    end
                    exp_hit = is_match;
                end
                if (exp_hit && !m_ovl) begin
                    m_hist.delete();
                end else begin
                    m_hist.push_back(bit'(d));
                    if (m_hist.size() > PAT_W - 1) void'(m_hist.pop_front());
                end
            end
            if (c) m_cnt = 0;
            else if (exp_hit && (m_cnt < CNT_MAX)) m_cnt++;
        end
        e = {exp_hit, (m_hist.size() == PAT_W - 1), CNT_W'(m_cnt)};
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic r, input logic vld, input logic d, input logic load,
                         input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m,
                         input logic o, input logic c);
        logic [EW-1:0] e;
        rst = r; din_vld = vld; din = d; cfg_load = load;
        cfg_pat = p; cfg_mask = m; cfg_ovl = o; cnt_clr = c;
        model_step(r, vld, d, load, p, m, o, c, e);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic bit_in(input logic d);
        drive(1'b0, 1'b1, d, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic load(input logic [PAT_W-1:0] p, input logic [PAT_W-1:0] m, input logic o);
        drive(1'b0, 1'b0, 1'b0, 1'b1, p, m, o, 1'b0);
    endtask

    task automatic stream(input logic [31:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) bit_in(bits[i]);
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [EW-1:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("hit", 32'(hit), 32'(e[EW-1]));
            chk("armed", 32'(armed), 32'(e[EW-2]));
`ifdef SEQ_DET_HIT_CNT_EN
            chk("hit_cnt", 32'(dut_cnt), 32'(e[CNT_W-1:0]));
`endif
            if (hit === 1'b1) hit_seen++;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        int base;
        int guard;
        logic [PAT_W-1:0] rp;
        logic [PAT_W-1:0] rm;

        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        settle();
        chk("reset_hit", 32'(hit), 32'd0);
        chk("reset_armed", 32'(armed), 32'd0);

        // default pattern 1010, overlapping: hits on bits 4 and 6
        base = hit_seen;
        stream(32'b101010, 6);
        gap();
        settle();
        chk("ovl_default_hits", 32'(hit_seen - base), 32'd2);

        // low three bits "101" with MSB don't-care, overlap
        base = hit_seen;
        load(4'b0101, 4'b0111, 1'b1);
        stream(32'b010101, 6);
        gap();
        settle();
        chk("ovl_masked_hits", 32'(hit_seen - base), 32'd2);

        // same, non-overlapping: completing bit is dropped, only one hit
        base = hit_seen;
        load(4'b0101, 4'b0111, 1'b0);
        stream(32'b010101, 6);
        gap();
        settle();
        chk("nonovl_hits", 32'(hit_seen - base), 32'd1);

        // gapped valid, pattern 1001 with bit 2 don't-care
        base = hit_seen;
        load(4'b1001, 4'b1011, 1'b1);
        bit_in(1'b1); gap(); gap(); gap();
        bit_in(1'b1); gap();
        bit_in(1'b0); gap(); gap();
        bit_in(1'b1); gap(); gap();
        settle();
        chk("gapped_mask_hit", 32'(hit_seen - base), 32'd1);

        base = hit_seen;
        load(4'b1001, 4'b1011, 1'b1);
        stream(32'b1011, 4);
        gap();
        settle();
        chk("mask_nohit", 32'(hit_seen - base), 32'd0);

        // cfg_load coincident with completing bit wins
        base = hit_seen;
        load(4'b1010, 4'b1111, 1'b1);
        stream(32'b101, 3);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'b1010, 4'b1111, 1'b1, 1'b0);
        gap();
        settle();
        chk("load_priority_hits", 32'(hit_seen - base), 32'd0);
        chk("load_priority_armed", 32'(armed), 32'd0);

        // reset coincident with completing bit suppresses the hit
        base = hit_seen;
        stream(32'b101, 3);
        drive(1'b1, 1'b1, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
        settle();
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_cnt", 32'(dut_cnt), 32'd0);
        gap();
        settle();
        chk("rst_suppress_hits", 32'(hit_seen - base), 32'd0);

        // mask all zero: every accepted bit once armed matches
        base = hit_seen;
        load(4'b0000, 4'b0000, 1'b1);
        stream(32'b01101, 5);
        gap();
        settle();
        chk("mask_zero_hits", 32'(hit_seen - base), 32'd2);

        // five overlapping hits saturate a 2-bit counter, then clear beats a hit
        drive(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b1);
        base = hit_seen;
        load(4'b0101, 4'b0111, 1'b1);
        stream(32'b010101010101, 12);
        settle();
        chk("cnt_five_hits", 32'(hit_seen - base), 32'd5);
`ifdef SEQ_DET_HIT_CNT_EN
        chk("cnt_saturated", 32'(dut_cnt), 32'd3);
`endif
        bit_in(1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
        settle();
        chk("clr_with_hit", 32'(hit), 32'd1);
`ifdef SEQ_DET_HIT_CNT_EN
        chk("clr_wins", 32'(dut_cnt), 32'd0);
`endif

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                drive(1'b1, 1'($urandom), 1'($urandom), 1'b0, '0, '0, 1'b0, 1'b0);
            end else if ($urandom_range(0, 39) == 0) begin
                rp = PAT_W'($urandom);
                case ($urandom_range(0, 3))
                    0:       rm = '0;
                    1:       rm = '1;
                    default: rm = PAT_W'($urandom);
                endcase
                drive(1'b0, 1'($urandom), 1'($urandom), 1'b1, rp, rm, 1'($urandom),
                      ($urandom_range(0, 29) == 0));
            end else begin
                drive(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom), 1'b0, '0, '0, 1'b0,
                      ($urandom_range(0, 29) == 0));
            end
        end
        gap();

        guard = 0;
        while ((exp_q.size() > 0) && (guard < 10)) begin
            @(negedge clk);
            guard++;
        end
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
